// File: rtl/pix_xfer_pkg.sv
// pix_xfer_pkg: shared FSM state encoding and transfer constants for the pixel-to-UART reader.
package pix_xfer_pkg;
    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, SEND_R, SEND_G, SEND_B, NEXT, FINISH
    } state_t;
    localparam int BYTES_PER_PIXEL = 3;
    localparam int ADDR_STRIDE = 4;
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer.
// Ports: clk, rst_n (sync, active-low), tx_start (accepted only while idle),
// tx_data (byte to send), txd (serial line, idle high), tx_busy (frame in progress).
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       tx_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    logic [CW-1:0] cnt;
    logic [3:0]    idx;
    logic [9:0]    shreg;
    // The frame (stop, data, start) is shifted out LSB first with ones filling
    // in behind, so bit 0 is the line level both during and between frames.
    assign txd = shreg[0];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_busy <= 1'b0;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '1;
        end else if (!tx_busy) begin
            if (tx_start) begin
                tx_busy <= 1'b1;
                shreg   <= {1'b1, tx_data, 1'b0};
                cnt     <= '0;
                idx     <= '0;
            end
        end else if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt   <= '0;
            shreg <= {1'b1, shreg[9:1]};
            idx   <= idx + 4'd1;
            if (idx == 4'd9)
                tx_busy <= 1'b0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/sdram_pixel_uart_reader.sv
// sdram_pixel_uart_reader: reads RGB pixel words over Avalon-MM and streams R,G,B bytes out of a UART.
// Ports: start/base_addr/pix_count request a frame; master_* is a single-outstanding Avalon-MM
// read master; uart_txd is the 8N1 line; busy spans the frame, done pulses once at its end.
module sdram_pixel_uart_reader
    import pix_xfer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] pix_count,
    input  logic             master_waitrequest,
    output logic [31:0]      master_address,
    output logic             master_read,
    input  logic [31:0]      master_readdata,
    input  logic             master_readdatavalid,
    output logic             uart_txd,
    output logic             busy,
    output logic             done
);
    state_t           state, state_nx;
    logic [31:0]      addr;
    logic [CNT_W-1:0] remaining;
    logic [23:0]      pixel;
    logic             sent, sending, take_data, tx_start, tx_busy;
    logic [7:0]       tx_data;
    logic             unused_hi;
    assign unused_hi      = ^master_readdata[31:24];
    assign master_address = addr;
    assign tx_data = state == SEND_R ? pixel[23:16] : state == SEND_G ? pixel[15:8] : pixel[7:0];
    always_comb begin
        state_nx    = state;
        master_read = 1'b0;
        take_data   = 1'b0;
        done        = 1'b0;
        busy        = state != IDLE;
        sending     = state inside {SEND_R, SEND_G, SEND_B};
        // sent marks that this state's byte has been handed over; a byte
        // completes once the serializer drops busy after that.
        tx_start    = sending && !sent && !tx_busy;
        case (state)
            IDLE:    if (start) state_nx = pix_count == '0 ? FINISH : RD_REQ;
            RD_REQ: begin
                master_read = 1'b1;
                if (!master_waitrequest) begin
                    take_data = master_readdatavalid;
                    state_nx  = master_readdatavalid ? SEND_R : RD_WAIT;
                end
            end
            RD_WAIT: begin
                take_data = master_readdatavalid;
                if (master_readdatavalid) state_nx = SEND_R;
            end
            SEND_R:  if (sent && !tx_busy) state_nx = SEND_G;
            SEND_G:  if (sent && !tx_busy) state_nx = SEND_B;
            SEND_B:  if (sent && !tx_busy) state_nx = NEXT;
            NEXT:    state_nx = remaining == CNT_W'(1) ? FINISH : RD_REQ;
            FINISH: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr      <= '0;
            remaining <= '0;
            pixel     <= '0;
            sent      <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                addr      <= base_addr;
                remaining <= pix_count;
            end
            if (take_data)
                pixel <= master_readdata[23:0];
            if (tx_start)
                sent <= 1'b1;
            else if (sending && sent && !tx_busy)
                sent <= 1'b0;
            if (state == NEXT) begin
                addr      <= addr + 32'(ADDR_STRIDE);
                remaining <= remaining - CNT_W'(1);
            end
        end
    end
    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .txd     (uart_txd),
        .tx_busy (tx_busy)
    );
endmodule

// File: doc/sdram_pixel_uart_reader.md
SDRAM_PIXEL_UART_READER -- requirements
Module: sdram_pixel_uart_reader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434: clk cycles per UART bit (50 MHz / 115200).
REQ-002 Parameter CNT_W, default 20: width of the pixel-count input.
REQ-003 clk  input  1  system clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a frame transfer.
REQ-006 base_addr  input  32  byte address of the first pixel word; sampled on an accepted start.
REQ-007 pix_count  input  CNT_W  number of pixels to send; sampled on an accepted start.
REQ-008 master_waitrequest  input  1  Avalon-MM slave stall.
REQ-009 master_address  output  32  Avalon-MM read address.
REQ-010 master_read  output  1  Avalon-MM read request.
REQ-011 master_readdata  input  32  read data; bits [23:0] = RGB pixel.
REQ-012 master_readdatavalid  input  1  read data qualifier.
REQ-013 uart_txd  output  1  8N1 serial output; idle high.
REQ-014 busy  output  1  high from the accepted start until done.
REQ-015 done  output  1  one-cycle pulse after the last stop bit of the frame.

Function
REQ-016 FSM states: IDLE, RD_REQ, RD_WAIT, SEND_R, SEND_G, SEND_B, NEXT, FINISH.
REQ-017 IDLE: start=1 is accepted; latch base_addr and pix_count; busy=1 next cycle; go to FINISH if pix_count=0, else go to RD_REQ.
REQ-018 start while busy=1 is ignored.
REQ-019 RD_REQ: master_read=1 and master_address=current address, held stable until a cycle with master_waitrequest=0; then go to RD_WAIT.
REQ-020 Only one read is outstanding at a time; master_read is 0 outside RD_REQ.
REQ-021 When master_readdatavalid=1 in RD_REQ (acceptance cycle) or in RD_WAIT, latch master_readdata[23:0] into the pixel register and go to SEND_R; bits [31:24] are discarded.
REQ-022 readdatavalid outside RD_REQ/RD_WAIT is ignored.
REQ-023 SEND_R/SEND_G/SEND_B send bytes [23:16], [15:8], [7:0] in that order; each state pulses tx_start for one cycle while the serializer is idle, then waits for it to become idle again.
REQ-024 NEXT: address += 4 (modulo 2^32, wrap allowed); remaining -= 1; go to FINISH if remaining reaches 0, else go to RD_REQ.
REQ-025 FINISH: done=1 for one cycle; busy=0 from the next cycle; return to IDLE.
REQ-026 Serializer frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts exactly CLKS_PER_BIT cycles, so one frame = 10*CLKS_PER_BIT cycles.
REQ-027 uart_txd changes at most one cycle after tx_start; the serializer is idle again on the cycle after the stop bit completes.
REQ-028 Per-pixel wire time = 30*CLKS_PER_BIT plus bus latency; no gap is required between the bytes of one pixel beyond the FSM handoff (≤2 cycles).

Reset
REQ-029 rst_n=0 forces the following on the next edge, including mid-frame or mid-byte: state=IDLE, master_read=0, master_address=0, uart_txd=1, busy=0, done=0, counters and pixel register cleared.
REQ-030 A read response arriving after reset is ignored.

Structure
REQ-031 Shared package pix_xfer_pkg holds the FSM state enum, the BYTES_PER_PIXEL=3 constant and the ADDR_STRIDE=4 constant.
REQ-032 One sub-module, uart_tx_byte (ports clk, rst_n, tx_start, tx_data[7:0], txd, tx_busy; parameter CLKS_PER_BIT), contains the bit-timing counter and shift register.

Verification (CLKS_PER_BIT=4)
REQ-033 base_addr=0x1000, pix_count=1, memory word 0xAA123456, zero waitstates -> one read at 0x1000; txd bytes 0x12, 0x34, 0x56; done pulses; total frame time ≈120 cycles.
REQ-034 pix_count=3, waitrequest held high 5 cycles on each read -> address/read stable during stall; reads at base, +4, +8; 9 bytes in order; one done pulse.
REQ-035 pix_count=0 -> no master_read; done pulses within 2 cycles of start; uart_txd stays 1.
REQ-036 base_addr=0xFFFFFFFC, pix_count=2 -> reads at 0xFFFFFFFC then 0x00000000.
REQ-037 rst_n low during the second byte of pixel 0 -> txd=1, master_read=0, busy=0 next cycle; late readdatavalid ignored; a new start runs cleanly.
REQ-038 start pulsed again mid-transfer -> ignored; byte count and done timing unchanged.
